// File: rtl/fpadd_pkg.sv
// Shared types and constants for the serial FP adder front end.
package fpadd_pkg;

    localparam int FP_W            = 32;
    localparam int TIMEOUT_DEFAULT = 1023;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SEND_A,
        S_SEND_B,
        S_BUSY,
        S_RESP
    } fpadd_state_t;

    // Watchdog width: enough bits to hold TIMEOUT, never less than one.
    function automatic int wd_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fpadd_if.sv
// Request/response handshake bundle between a client and the sequencer.
interface fpadd_if;
    import fpadd_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [FP_W-1:0] req_a;
    logic [FP_W-1:0] req_b;
    logic            req_sub;
    logic            res_valid;
    logic            res_ready;
    logic [FP_W-1:0] res_sum;

    modport master (
        output req_valid, req_a, req_b, req_sub, res_ready,
        input  req_ready, res_valid, res_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, res_ready,
        output req_ready, res_valid, res_sum
    );

endinterface

// File: rtl/fpadd_ready_edge.sv
// Detects the first cycle (W0) of each adder issue window.
module fpadd_ready_edge (
    input  logic clock,
    input  logic nreset,
    input  logic i_fp_ready,
    output logic o_rise
);

    logic r_ready_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_ready_q <= 1'b0;
        end else begin
            r_ready_q <= i_fp_ready;
        end
    end

    assign o_rise = i_fp_ready & ~r_ready_q;

endmodule

// File: rtl/fpadd_sequencer.sv
// Client front end: captures an operand pair, serialises it onto the adder's
// shared operand bus inside an issue window and returns the adder's result.
module fpadd_sequencer
    import fpadd_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             nreset,
    fpadd_if.slave           bus,
    input  logic             fp_ready,
    output logic [FP_W-1:0]  fp_a,
    input  logic [FP_W-1:0]  fp_sum,
    output logic             err_timeout,
    output logic [CNT_W-1:0] op_count
);

    localparam int               WD_W   = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT);

    logic w_rise;

    fpadd_state_t     r_state;
    logic             r_req_ready;
    logic             r_res_valid;
    logic [FP_W-1:0]  r_res_sum;
    logic [FP_W-1:0]  r_fp_a;
    logic [FP_W-1:0]  r_a;
    logic [FP_W-1:0]  r_b;
    logic [WD_W-1:0]  r_wd;
    logic             r_err;
    logic [CNT_W-1:0] r_count;

    fpadd_ready_edge u_edge (
        .clock      (clock),
        .nreset     (nreset),
        .i_fp_ready (fp_ready),
        .o_rise     (w_rise)
    );

    // fp_a is registered: it is loaded on the transition into SEND_A/SEND_B
    // and falls back to zero otherwise, so unused windows compute 0+0.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_fp_a      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_wd        <= '0;
            r_err       <= 1'b0;
            r_count     <= '0;
        end else begin
            r_fp_a <= '0;
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (bus.req_valid && r_req_ready) begin
                        r_a         <= bus.req_a;
                        r_b         <= {bus.req_b[FP_W-1] ^ bus.req_sub, bus.req_b[FP_W-2:0]};
                        r_req_ready <= 1'b0;
                        r_wd        <= '0;
                        if (w_rise) begin
                            r_state <= S_SEND_A;
                            r_fp_a  <= bus.req_a;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_rise) begin
                        r_state <= S_SEND_A;
                        r_fp_a  <= r_a;
                    end else if (r_wd == WD_MAX) begin
                        r_state     <= S_IDLE;
                        r_err       <= 1'b1;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_SEND_A: begin
                    r_state <= S_SEND_B;
                    r_fp_a  <= r_b;
                end
                S_SEND_B: begin
                    r_state <= S_BUSY;
                    r_wd    <= '0;
                end
                S_BUSY: begin
                    if (w_rise) begin
                        r_state     <= S_RESP;
                        r_res_sum   <= fp_sum;
                        r_res_valid <= 1'b1;
                    end else if (r_wd == WD_MAX) begin
                        r_state     <= S_IDLE;
                        r_err       <= 1'b1;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_count     <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_sum   = r_res_sum;
    assign fp_a          = r_fp_a;
    assign err_timeout   = r_err;
    assign op_count      = r_count;

endmodule

// File: tb/tb_fpadd_sequencer.sv
// Scoreboard bench for fpadd_sequencer with a free-running stub adder.
module tb_fpadd_sequencer;
    import fpadd_pkg::*;

    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             nreset = 1'b0;
    logic             fp_ready;
    logic [31:0]      fp_a;
    logic [31:0]      fp_sum;
    logic             err_timeout;
    logic [CNT_W-1:0] op_count;

    fpadd_if bus_if ();

    fpadd_sequencer #(.TIMEOUT(1023), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .bus         (bus_if),
        .fp_ready    (fp_ready),
        .fp_a        (fp_a),
        .fp_sum      (fp_sum),
        .err_timeout (err_timeout),
        .op_count    (op_count)
    );

    always #5 clock = ~clock;

    // Stub adder: 8-cycle window period, W0/W1 at phases 0/1.
    logic [2:0]  ph;
    logic        fp_en = 1'b1;
    logic [31:0] add_a;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40400000, 32'hBF800000}: return 32'h40000000;
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h40000000, 32'h40400000}: return 32'h40A00000;
            64'h0:                        return 32'h00000000;
            default:                      return 32'hFFFFFFFF;
        endcase
    endfunction

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            ph     <= 3'd0;
            add_a  <= 32'h0;
            fp_sum <= 32'h0;
        end else begin
            ph <= ph + 3'd1;
            if (ph == 3'd1) add_a <= fp_a;
            if (ph == 3'd2) fp_sum <= fadd(add_a, fp_a);
        end
    end

    assign fp_ready = fp_en & (ph <= 3'd1);

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each delivered result and checks hold.
    initial begin
        logic        prev_v;
        logic        prev_r;
        logic [31:0] prev_s;
        logic [31:0] exp;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_s = 32'h0;
        forever begin
            @(negedge clock);
            if (!nreset) begin
                prev_v = 1'b0;
            end else begin
                if (prev_v && !prev_r) begin
                    chk("hold_valid", {31'h0, bus_if.res_valid}, 32'h1);
                    chk("hold_sum", bus_if.res_sum, prev_s);
                end
                if (bus_if.res_valid && bus_if.res_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got %h, expected no result", bus_if.res_sum);
                    end else begin
                        exp = sb.pop_front();
                        chk("res_sum", bus_if.res_sum, exp);
                    end
                end
                prev_v = bus_if.res_valid;
                prev_r = bus_if.res_ready;
                prev_s = bus_if.res_sum;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int n = 0;
        @(negedge clock);
        while (!bus_if.req_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (!bus_if.req_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_wait: req_ready got 0, expected 1");
            return;
        end
        bus_if.req_a     = a;
        bus_if.req_b     = b;
        bus_if.req_sub   = sub;
        bus_if.req_valid = 1'b1;
        @(posedge clock);
        #1 bus_if.req_valid = 1'b0;
    endtask

    // Waits for operand A on the bus, then expects B on the following cycle.
    task automatic check_bus(input logic [31:0] a, input logic [31:0] b, output int n);
        n = 0;
        @(negedge clock);
        while (fp_a == 32'h0 && n < 64) begin
            @(negedge clock);
            n++;
        end
        chk("fp_a_opA", fp_a, a);
        chk("fp_ready_in_W1", {31'h0, fp_ready}, 32'h1);
        @(negedge clock);
        chk("fp_a_opB", fp_a, b);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        @(negedge clock);
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", {31'h0, bus_if.req_ready}, 32'h0);
        chk("rst_res_valid", {31'h0, bus_if.res_valid}, 32'h0);
        chk("rst_res_sum", bus_if.res_sum, 32'h0);
        chk("rst_fp_a", fp_a, 32'h0);
        chk("rst_err", {31'h0, err_timeout}, 32'h0);
        chk("rst_op_count", {16'h0, op_count}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1 nreset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals();
        #1 nreset = 1'b1;
        @(negedge clock);
        chk("req_ready_after_rst", {31'h0, bus_if.req_ready}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation got stuck, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        bus_if.req_valid = 1'b0;
        bus_if.req_a     = 32'h0;
        bus_if.req_b     = 32'h0;
        bus_if.req_sub   = 1'b0;
        bus_if.res_ready = 1'b1;

        repeat (3) @(negedge clock);
        check_reset_vals();
        #1 nreset = 1'b1;
        @(negedge clock);
        chk("req_ready_after_rst", {31'h0, bus_if.req_ready}, 32'h1);

        // 1.0 + 2.0
        sb.push_back(32'h40400000);
        issue(32'h3F800000, 32'h40000000, 1'b0);
        check_bus(32'h3F800000, 32'h40000000, n);
        drain();
        chk("op_count_1", {16'h0, op_count}, 32'd1);

        // 3.0 - 1.0: B sign flipped on the bus
        sb.push_back(32'h40000000);
        issue(32'h40400000, 32'h3F800000, 1'b1);
        check_bus(32'h40400000, 32'hBF800000, n);
        drain();
        chk("op_count_2", {16'h0, op_count}, 32'd2);

        // Request coincident with W0
        sb.push_back(32'h40A00000);
        n = 0;
        @(negedge clock);
        while (!(bus_if.req_ready && ph == 3'd0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        bus_if.req_a     = 32'h40000000;
        bus_if.req_b     = 32'h40400000;
        bus_if.req_sub   = 1'b0;
        bus_if.req_valid = 1'b1;
        @(posedge clock);
        #1 bus_if.req_valid = 1'b0;
        check_bus(32'h40000000, 32'h40400000, n);
        chk("w0_accept_latency", n, 32'd0);
        drain();
        chk("op_count_3", {16'h0, op_count}, 32'd3);

        // Back-to-back with a stalled consumer
        do_reset();
        @(posedge clock);
        #1 bus_if.res_ready = 1'b0;
        sb.push_back(32'h40A00000);
        sb.push_back(32'h40400000);
        issue(32'h40000000, 32'h40400000, 1'b0);
        n = 0;
        while (!bus_if.res_valid && n < 64) begin
            @(negedge clock);
            n++;
        end
        chk("stall_res_valid", {31'h0, bus_if.res_valid}, 32'h1);
        repeat (20) begin
            @(negedge clock);
            chk("stall_req_ready", {31'h0, bus_if.req_ready}, 32'h0);
        end
        @(posedge clock);
        #1 bus_if.res_ready = 1'b1;
        issue(32'h3F800000, 32'h40000000, 1'b0);
        drain();
        chk("op_count_b2b", {16'h0, op_count}, 32'd2);

        // Adder silent: watchdog expiry in WAIT
        @(posedge clock);
        #1 fp_en = 1'b0;
        issue(32'h3F800000, 32'h40000000, 1'b0);
        n = 0;
        while (!err_timeout && n < 1100) begin
            @(negedge clock);
            n++;
        end
        chk("timeout_cycles", n, 32'd1025);
        chk("timeout_err", {31'h0, err_timeout}, 32'h1);
        chk("timeout_idle", {31'h0, bus_if.req_ready}, 32'h1);
        chk("timeout_no_res", {31'h0, bus_if.res_valid}, 32'h0);
        @(posedge clock);
        #1 fp_en = 1'b1;
        repeat (20) @(negedge clock);
        chk("err_sticky", {31'h0, err_timeout}, 32'h1);
        chk("op_count_after_to", {16'h0, op_count}, 32'd2);

        // Reset while BUSY drops the operation
        issue(32'h40000000, 32'h40400000, 1'b0);
        check_bus(32'h40000000, 32'h40400000, n);
        repeat (2) @(negedge clock);
        do_reset();
        sb.push_back(32'h40000000);
        issue(32'h3F800000, 32'h3F800000, 1'b0);
        check_bus(32'h3F800000, 32'h3F800000, n);
        drain();
        chk("op_count_post_rst", {16'h0, op_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpadd_sequencer.md
# fpadd_sequencer

- Client-side front end for the team's serial floating-point adder.
- Accepts a single-precision operand pair on a valid/ready request port, with an optional subtract flag.
- Waits for the adder's issue window, then serialises operand A and operand B onto the adder's shared 32-bit operand bus on consecutive cycles.
- Captures the adder's result when the next issue window opens and returns it on a valid/ready response port, with a timeout watchdog and an operation counter.

## Interface
- TIMEOUT, 1023: maximum cycles to wait for an adder issue window before flagging an error.
- CNT_W, 16: width of the completed-operation counter.
- clock  in  1  clock.
- nreset  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request operands valid.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  32  IEEE-754 single operand A.
- req_b  in  32  IEEE-754 single operand B.
- req_sub  in  1  1 = compute A−B (B sign bit inverted at capture).
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_sum  out  32  result word.
- fp_ready  in  1  adder ready output.
- fp_a  out  32  adder operand bus.
- fp_sum  in  32  adder sum output.
- err_timeout  out  1  sticky: watchdog expired; cleared only by reset.
- op_count  out  CNT_W  count of results delivered; wraps.

## Operation
- Adder protocol, decided:
  - The adder holds fp_ready high for exactly two cycles per operation; call these window cycles W0 and W1.
  - The adder samples fp_a at the end of W1 (operand A) and at the end of the cycle after W1 (operand B).
  - fp_sum is already valid in W0 of the next window.
  - The adder free-runs; unused windows load whatever is on fp_a.
- Window detect: ready_q is fp_ready delayed one cycle; rise = fp_ready & ~ready_q. A rise cycle is W0.
- Request capture (IDLE, req_valid & req_ready):
  - a_q ← req_a.
  - b_q ← {req_b[31]^req_sub, req_b[30:0]}.
- fp_a: a_q in SEND_A, b_q in SEND_B, 32'h0 in every other state. Idle windows therefore compute 0+0, and those results are discarded.
- States:
  - IDLE: req_ready=1. On accept, go to SEND_A if rise is true in the same cycle, else WAIT.
  - WAIT: on rise → SEND_A. On watchdog expiry → IDLE, set err_timeout.
  - SEND_A: one cycle → SEND_B.
  - SEND_B: one cycle → BUSY.
  - BUSY: on rise → res_sum ← fp_sum, → RESP. On watchdog expiry → IDLE, set err_timeout, no response.
  - RESP: res_valid=1. On res_ready → op_count+1, → IDLE.
- Watchdog: 10-bit counter, sized ≥ clog2(TIMEOUT+1).
  - Cleared on entry to WAIT and to BUSY; increments each cycle in those states.
  - Expires when count == TIMEOUT with no rise.
- One operation outstanding at a time; no request is accepted in WAIT through RESP.

## Timing
- Reset values: req_ready=0 during reset and 1 from the first cycle after release; res_valid=0; res_sum=0; fp_a=0; err_timeout=0; op_count=0; ready_q=0; state IDLE.
- Accept in the W0 cycle: fp_a=A in W1, fp_a=B in the following cycle.
- Accept in any other cycle: A is issued in the W1 of the next window.
- Latency: result capture at the next rise after SEND_B; res_valid asserts the cycle after that rise. Total latency is variable and set by the adder.
- res_sum and res_valid are held stable while res_valid & ~res_ready. Windows occurring during RESP are ignored.
- The counter wraps from all-ones to 0.
- Asynchronous reset mid-operation: returns to IDLE immediately, drops any pending operation, fp_a=0. The adder shares the same reset.

## Structure
- Package fpadd_pkg holds:
  - the state enum typedef;
  - FP_W=32;
  - TIMEOUT_DEFAULT=1023.
- Sub-module fpadd_ready_edge (ready_q register plus rise output) is natural. Everything else is a single FSM module.

## Test plan
- 1.0 + 2.0: req_a=3F800000, req_b=40000000, req_sub=0 → res_sum=40400000, op_count=1.
- 3.0 − 1.0: req_a=40400000, req_b=3F800000, req_sub=1 → fp_a=BF800000 in SEND_B; res_sum=40000000.
- Request with req_valid coincident with the W0 rise → fp_a=A the next cycle, B the cycle after; the idle 0+0 result is never returned.
- Back-to-back requests with res_ready held low 20 cycles → res_valid and res_sum stable, req_ready=0; the second result arrives correctly after release; op_count=2.
- fp_ready tied low, one request → err_timeout=1 after 1023 WAIT cycles, state IDLE, res_valid never asserts.
- nreset pulsed during BUSY → all outputs at reset values; the next request 1.0+1.0 returns 40000000.
